mono_mode_ctrl: RTL and testbench
=================================

Name: mono_mode_ctrl

Overview:
- Controller that sequences the 2-bit monochrome mode selecting the colour, green, amber or B/W output path in the VGA top level.
- Takes mode requests from a debounced front-panel/joystick button, which cycles the mode, and from a CPU register write, which sets the mode directly.
- Commits a new mode only at the start of vertical sync, so a frame is never split between two palettes.
- Drives a status LED pulse after each commit. Sits in the clk_vga domain beside the output colour mux.

Parameters:
- DEBOUNCE_CYCLES, 285710, clk_vga cycles the button must be stable before it is accepted (10 ms at 28.571 MHz).
- DB_W, 19, width of the debounce counter; must satisfy 2^DB_W > DEBOUNCE_CYCLES.
- VSYNC_ACTIVE, 1'b0, active level of vsync_in.
- BLINK_FRAMES, 8, number of vsync assertions led_blink stays high after a commit; range 1..255.

Ports:
- clk_vga  in  1  pixel clock (28.571 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- btn_n  in  1  raw button, active-low, asynchronous to clk_vga.
- vsync_in  in  1  VGA vertical sync, as sent to the connector.
- cpu_wr  in  1  single-cycle write strobe, synchronous to clk_vga.
- cpu_mode  in  2  mode value for cpu_wr.
- mode  out  2  committed mode (0 colour, 1 green, 2 amber, 3 B/W) feeding the colour mux.
- req_mode  out  2  latest requested mode (readback).
- pending  out  1  a request is waiting for vsync.
- led_blink  out  1  commit indicator.

Behaviour:
- Reset is asynchronous and active-low. All outputs go to 0. Internal state on reset: debounced button level = 1 (released), button and vsync synchronizers = inactive levels, debounce counter = 0, blink counter = 0.
- Button path:
  - Two-flop synchronizer on btn_n.
  - If the synced level equals the debounced level, the counter is cleared.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced value and the counter is cleared.
  - A press event is a 1->0 transition of the debounced level, one cycle wide. Release produces no event.
  - Latency from btn_n falling (held stable) to the press event: 2 + DEBOUNCE_CYCLES cycles.
- Request register:
  - On a press, req_mode <= req_mode + 1, mod 4 (3 wraps to 0).
  - On cpu_wr, req_mode <= cpu_mode.
  - If both occur in the same cycle, cpu_wr wins and the press is discarded.
  - Any request sets pending on the next edge, even if the new value equals mode.
- Vsync path:
  - Two-flop synchronizer on vsync_in, plus one history flop.
  - The frame edge is a one-cycle pulse on the inactive->active transition of the synced signal.
- Commit:
  - On a frame edge with pending=1: mode <= req_mode, pending <= 0, and the blink counter loads BLINK_FRAMES.
  - Commit latency: mode updates on the clock edge after the pulse cycle.
  - A frame edge with pending=0 changes nothing except blink counting.
- Simultaneous request and frame edge:
  - The commit uses the pre-update req_mode.
  - The new request updates req_mode and leaves pending=1, so it commits on the next frame.
  - Rule: pending_next = (pending & ~commit) | new_request.
- Blink:
  - led_blink = (blink counter != 0).
  - The counter decrements on each frame edge that is not a commit.
  - A commit while already blinking reloads the counter to BLINK_FRAMES.
- Multiple requests within one frame collapse: only the final req_mode is committed.
- Reset asserted mid-debounce or mid-pending aborts everything: mode returns to colour and no commit occurs after release.
- If vsync_in never toggles, pending stays asserted indefinitely. This is legal.

Decomposition:
- Package mono_pkg holds:
  - MODE_COLOR=2'd0, MODE_GREEN=2'd1, MODE_AMBER=2'd2, MODE_BW=2'd3;
  - the 2-bit mode type.
- One sub-module, btn_debounce:
  - contains the synchronizer, counter and debounced level;
  - parameters DEBOUNCE_CYCLES and DB_W;
  - outputs the one-cycle press pulse.
- The vsync edge detect, request/commit logic and blink counter stay in the top module.

Test Plan (DEBOUNCE_CYCLES=16, DB_W=5, BLINK_FRAMES=3, vsync active-low pulse every 200 cycles):
- Reset release, no stimulus for 3 frames -> mode=0, req_mode=0, pending=0, led_blink=0 throughout.
- btn_n low for 40 cycles with 3-cycle bounce glitches at its start:
  - exactly one press event; req_mode=1 and pending=1 at cycle 18 after the last glitch;
  - mode=1 one cycle after the next vsync edge;
  - led_blink high for exactly 3 frames.
- btn_n pulses of 10 cycles (shorter than the debounce time) -> no press; req_mode and pending unchanged.
- Four accepted presses within one frame starting from mode=0 -> req_mode sequence 1,2,3,0; single commit gives mode=0; pending clears.
- cpu_wr with cpu_mode=2 in the same cycle as a debounced press -> req_mode=2 (press ignored); mode=2 after the next vsync.
- cpu_wr with cpu_mode=3 in the exact cycle of a frame edge while pending with req_mode=1:
  - mode=1 commits;
  - req_mode=3 and pending=1 remain;
  - mode=3 at the following frame.
- Assert rst_n mid-frame while pending=1 -> all outputs 0 immediately; no commit after release.

Source files
------------

// File: rtl/mono_pkg.sv
// Mode encodings and helpers shared by the monochrome mode controller.
//   mode_t     : 2-bit output-path select (colour / green / amber / B/W)
//   mode_next  : front-panel cycling order, wrapping B/W back to colour
package mono_pkg;

  localparam int unsigned MODE_W = 2;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_COLOR = 2'd0;
  localparam mode_t MODE_GREEN = 2'd1;
  localparam mode_t MODE_AMBER = 2'd2;
  localparam mode_t MODE_BW    = 2'd3;

  // Button cycles colour -> green -> amber -> B/W -> colour.
  function automatic mode_t mode_next(input mode_t m);
    mode_t n;
    case (m)
      MODE_COLOR: n = MODE_GREEN;
      MODE_GREEN: n = MODE_AMBER;
      MODE_AMBER: n = MODE_BW;
      default:    n = MODE_COLOR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mono_mode_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and debounced
// level for an active-low front-panel button.
//   clk, rst_n : clock, async active-low reset
//   btn_n      : raw button, active-low, asynchronous to clk
//   press      : one-cycle pulse on each accepted press (debounced 1->0)
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 285710,
  parameter int unsigned DB_W            = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            btn_meta;
  logic            btn_sync;
  logic            db_level;
  logic [DB_W-1:0] db_cnt;

  // Synchronizer; idles at the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 1'b1;
      btn_sync <= 1'b1;
    end else begin
      btn_meta <= btn_n;
      btn_sync <= btn_meta;
    end
  end

  // Accept a new level only after it has been stable for DEBOUNCE_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_level <= 1'b1;
      db_cnt   <= '0;
      press    <= 1'b0;
    end else if (btn_sync == db_level) begin
      db_cnt <= '0;
      press  <= 1'b0;
    end else if (db_cnt == CNT_LAST) begin
      db_level <= btn_sync;
      db_cnt   <= '0;
      // Old level high means this flip is 1->0, i.e. a press.
      press    <= db_level;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
      press  <= 1'b0;
    end
  end

endmodule

// File: rtl/mono_mode_ctrl.sv
// Monochrome mode sequencer for the VGA colour mux. Button presses cycle the
// requested mode, CPU writes set it directly; the request is committed only
// at the start of vertical sync so a frame never mixes palettes. An LED
// indicator stays lit for BLINK_FRAMES frames after each commit.
//   clk_vga, rst_n : pixel clock, async active-low reset
//   btn_n          : raw front-panel button, active-low, asynchronous
//   vsync_in       : VGA vertical sync as driven to the connector
//   cpu_wr         : one-cycle write strobe carrying cpu_mode
//   mode           : committed mode feeding the colour mux
//   req_mode       : latest requested mode (readback)
//   pending        : request waiting for the next frame edge
//   led_blink      : commit indicator
module mono_mode_ctrl
  import mono_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 285710,
  parameter int unsigned DB_W            = 19,
  parameter logic        VSYNC_ACTIVE    = 1'b0,
  parameter int unsigned BLINK_FRAMES    = 8
) (
  input  logic       clk_vga,
  input  logic       rst_n,
  input  logic       btn_n,
  input  logic       vsync_in,
  input  logic       cpu_wr,
  input  logic [1:0] cpu_mode,
  output logic [1:0] mode,
  output logic [1:0] req_mode,
  output logic       pending,
  output logic       led_blink
);

  localparam int unsigned BLINK_W = 8;
  localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_FRAMES);

  logic               press;
  logic               vs_meta;
  logic               vs_sync;
  logic               vs_hist;
  logic               frame_edge;
  logic               commit;
  logic               new_req;
  mode_t              req_next;
  logic [BLINK_W-1:0] blink_cnt;
  logic [BLINK_W-1:0] blink_next;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_W            (DB_W)
  ) u_btn_debounce (
    .clk   (clk_vga),
    .rst_n (rst_n),
    .btn_n (btn_n),
    .press (press)
  );

  // Vsync synchronizer plus one history flop for edge detection.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      vs_meta <= ~VSYNC_ACTIVE;
      vs_sync <= ~VSYNC_ACTIVE;
      vs_hist <= ~VSYNC_ACTIVE;
    end else begin
      vs_meta <= vsync_in;
      vs_sync <= vs_meta;
      vs_hist <= vs_sync;
    end
  end

  // Request/commit/blink next-state. A request landing on a frame edge is
  // held for the following frame; the commit uses the pre-update req_mode.
  always_comb begin
    frame_edge = (vs_sync == VSYNC_ACTIVE) && (vs_hist != VSYNC_ACTIVE);
    commit     = frame_edge && pending;
    new_req    = cpu_wr || press;
    req_next   = req_mode;
    blink_next = blink_cnt;
    if (cpu_wr) begin
      req_next = cpu_mode;
    end else if (press) begin
      req_next = mode_next(req_mode);
    end
    if (commit) begin
      blink_next = BLINK_LOAD;
    end else if (frame_edge && (blink_cnt != '0)) begin
      blink_next = blink_cnt - BLINK_W'(1);
    end
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      mode      <= MODE_COLOR;
      req_mode  <= MODE_COLOR;
      pending   <= 1'b0;
      blink_cnt <= '0;
      led_blink <= 1'b0;
    end else begin
      if (commit) begin
        mode <= req_mode;
      end
      req_mode  <= req_next;
      pending   <= (pending && !commit) || new_req;
      blink_cnt <= blink_next;
      led_blink <= (blink_next != '0);
    end
  end

endmodule

// File: tb/tb_mono_mode_ctrl.sv
// Directed bench for mono_mode_ctrl with a history-based reference model.
module tb_mono_mode_ctrl;

  localparam int unsigned DC    = 16;
  localparam int unsigned DBW   = 5;
  localparam int unsigned BLINK = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_n;
  logic       vsync_in;
  logic       cpu_wr;
  logic [1:0] cpu_mode;
  logic [1:0] mode;
  logic [1:0] req_mode;
  logic       pending;
  logic       led_blink;

  mono_mode_ctrl #(
    .DEBOUNCE_CYCLES (DC),
    .DB_W            (DBW),
    .VSYNC_ACTIVE    (1'b0),
    .BLINK_FRAMES    (BLINK)
  ) dut (
    .clk_vga   (clk),
    .rst_n     (rst_n),
    .btn_n     (btn_n),
    .vsync_in  (vsync_in),
    .cpu_wr    (cpu_wr),
    .cpu_mode  (cpu_mode),
    .mode      (mode),
    .req_mode  (req_mode),
    .pending   (pending),
    .led_blink (led_blink)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // bh[0] is the raw button seen at the previous edge, bh[k] k edges earlier;
  // the debounced level flips once DC consecutive synchronized samples
  // (raw samples two edges old) all disagree with it.
  logic [0:DC] bh;
  logic [0:2]  vh;
  logic        m_db;
  logic        m_press;
  logic [1:0]  m_mode;
  logic [1:0]  m_req;
  logic        m_pend;
  int          m_blink;
  logic        m_flip;
  logic        m_frame;
  logic        m_commit;

  always_comb begin
    m_flip = 1'b1;
    for (int i = 1; i <= int'(DC); i++) begin
      if (bh[i] == m_db) m_flip = 1'b0;
    end
    // Synced vsync went high->low: sample two edges back low, three back high.
    m_frame  = !vh[1] && vh[2];
    m_commit = m_frame && m_pend;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bh      <= '1;
      vh      <= '1;
      m_db    <= 1'b1;
      m_press <= 1'b0;
      m_mode  <= 2'd0;
      m_req   <= 2'd0;
      m_pend  <= 1'b0;
      m_blink <= 0;
    end else begin
      bh      <= {btn_n, bh[0:DC-1]};
      vh      <= {vsync_in, vh[0:1]};
      m_db    <= m_flip ? ~m_db : m_db;
      m_press <= m_flip && m_db;
      if (m_commit) m_mode <= m_req;
      if (cpu_wr)       m_req <= cpu_mode;
      else if (m_press) m_req <= 2'((m_req + 2'd1) % 4);
      m_pend <= (m_pend && !m_commit) || cpu_wr || m_press;
      if (m_commit)                     m_blink <= int'(BLINK);
      else if (m_frame && m_blink > 0)  m_blink <= m_blink - 1;
    end
  end

  // ---------------- checking ----------------
  int    n_checks = 0;
  int    n_fail   = 0;
  logic  chk_en   = 1'b0;
  int    lit_seq  = 0;
  int    seen_seq = 0;
  string lit_name;
  int    lit_m, lit_r, lit_p, lit_l;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_mode",    int'(mode),      int'(m_mode));
      chk("cyc_req",     int'(req_mode),  int'(m_req));
      chk("cyc_pending", int'(pending),   int'(m_pend));
      chk("cyc_led",     int'(led_blink), int'(m_blink != 0));
      if (lit_seq != seen_seq) begin
        seen_seq = lit_seq;
        if (lit_m >= 0) begin
          chk({lit_name, "/mode"},       int'(mode),   lit_m);
          chk({lit_name, "/mode_model"}, int'(m_mode), lit_m);
        end
        if (lit_r >= 0) begin
          chk({lit_name, "/req"},        int'(req_mode), lit_r);
          chk({lit_name, "/req_model"},  int'(m_req),    lit_r);
        end
        if (lit_p >= 0) begin
          chk({lit_name, "/pend"},       int'(pending), lit_p);
          chk({lit_name, "/pend_model"}, int'(m_pend),  lit_p);
        end
        if (lit_l >= 0) begin
          chk({lit_name, "/led"},        int'(led_blink),     lit_l);
          chk({lit_name, "/led_model"},  int'(m_blink != 0),  lit_l);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int vcnt = 100;

  // Advance one cycle; vsync is low for the first 8 of every 200 cycles.
  task automatic tick();
    @(posedge clk);
    #2;
    vcnt     = (vcnt == 199) ? 0 : vcnt + 1;
    vsync_in = (vcnt < 8) ? 1'b0 : 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_vcnt(input int n);
    do tick(); while (vcnt != n);
  endtask

  // Post hand-computed expectations (-1 = don't care) for this cycle.
  task automatic post(input string nm, input int m, input int r, input int p, input int l);
    lit_name = nm;
    lit_m    = m;
    lit_r    = r;
    lit_p    = p;
    lit_l    = l;
    lit_seq++;
  endtask

  task automatic cpu_write(input logic [1:0] v);
    cpu_mode = v;
    cpu_wr   = 1'b1;
    tick();
    cpu_wr   = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    btn_n    = 1'b1;
    vsync_in = 1'b1;
    cpu_wr   = 1'b0;
    cpu_mode = 2'd0;
    ticks(4);
    chk_en = 1'b1;
    post("reset", 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;

    // Idle for three frames.
    ticks(600);
    post("idle", 0, 0, 0, 0);

    // Bouncy press: two 3-cycle glitches, then held low for 40 cycles.
    wait_vcnt(10);
    btn_n = 1'b0; ticks(3);
    btn_n = 1'b1; ticks(3);
    btn_n = 1'b0; ticks(3);
    btn_n = 1'b1; ticks(3);
    btn_n = 1'b0; ticks(18);
    post("press_early", 0, 0, 0, 0);
    tick();
    post("press_req", 0, 1, 1, 0);
    ticks(21);
    btn_n = 1'b1;
    wait_vcnt(2);
    post("pre_commit", 0, 1, 1, 0);
    tick();
    post("commit1", 1, 1, 0, 1);
    wait_vcnt(3);
    wait_vcnt(3);
    post("blink_f2", 1, 1, 0, 1);
    wait_vcnt(2);
    post("blink_last", 1, 1, 0, 1);
    tick();
    post("blink_off", 1, 1, 0, 0);

    // Pulses shorter than the debounce window are ignored.
    for (int k = 0; k < 2; k++) begin
      btn_n = 1'b0; ticks(10);
      btn_n = 1'b1; ticks(30);
    end
    post("short_pulse", 1, 1, 0, 0);

    // Back to colour, then four presses inside one frame.
    cpu_write(2'd0);
    post("cpu_zero", 1, 0, 1, 0);
    wait_vcnt(3);
    post("commit_zero", 0, 0, 0, 1);
    wait_vcnt(5);
    for (int k = 0; k < 4; k++) begin
      btn_n = 1'b0; ticks(20);
      post("multi_press", 0, (k + 1) % 4, 1, -1);
      btn_n = 1'b1; ticks(20);
    end
    wait_vcnt(3);
    post("multi_commit", 0, 0, 0, 1);

    // CPU write in the same cycle the press would update req_mode.
    wait_vcnt(10);
    btn_n = 1'b0;
    ticks(18);
    cpu_write(2'd2);
    post("cpu_vs_press", 0, 2, 1, -1);
    ticks(20);
    btn_n = 1'b1;
    ticks(20);
    wait_vcnt(3);
    post("commit_cpu", 2, 2, 0, 1);

    // CPU write landing on the frame-edge commit cycle.
    wait_vcnt(50);
    cpu_write(2'd1);
    post("pend_one", 2, 1, 1, -1);
    wait_vcnt(2);
    cpu_write(2'd3);
    post("edge_write", 1, 3, 1, 1);
    wait_vcnt(3);
    post("edge_followup", 3, 3, 0, 1);

    // Reset mid-frame with a request pending.
    wait_vcnt(50);
    cpu_write(2'd2);
    post("pend_pre_rst", 3, 2, 1, -1);
    tick();
    rst_n = 1'b0;
    post("rst_async", 0, 0, 0, 0);
    ticks(3);
    rst_n = 1'b1;
    wait_vcnt(3);
    wait_vcnt(3);
    post("after_rst", 0, 0, 0, 0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
